ex_mem_pipe_reg: RTL and testbench

//  EX->MEM pipeline register with valid/ready handshake, 2-entry skid buffer and flush.

---
 rtl/ex_mem_pipe_reg_pkg.sv | 38 +++
 rtl/ex_mem_pipe_reg_if.sv | 38 +++
 rtl/ex_mem_pipe_reg_skid_slot.sv | 37 +++
 rtl/ex_mem_pipe_reg.sv | 133 +++++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_pipe_reg_pkg.sv
// -----------------------------------------------------------------------------
// arm_pipe_pkg
//   Shared definitions for the ARM pipeline registers.
//   - DEFAULT_DATA_W / DEFAULT_DEST_W : default payload field widths
//   - ex_mem_payload_t                : EX->MEM payload at the default widths
//   - PAYLOAD_W                       : packed width of ex_mem_payload_t
//   - pipe_state_t                    : occupancy of a two-entry pipe register
//   - payload_w()                     : packed payload width for arbitrary widths
// -----------------------------------------------------------------------------
package arm_pipe_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEST_W = 4;

  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] pc;
    logic [DEFAULT_DATA_W-1:0] alu_res;
    logic [DEFAULT_DATA_W-1:0] val_rm;
    logic [DEFAULT_DEST_W-1:0] dest;
    logic                      wb_en;
    logic                      mem_r_en;
    logic                      mem_w_en;
  } ex_mem_payload_t;

  localparam int PAYLOAD_W = $bits(ex_mem_payload_t);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

  // Field order matches ex_mem_payload_t: pc, alu_res, val_rm, dest, 3 controls.
  function automatic int payload_w(input int data_w, input int dest_w);
    return 3 * data_w + dest_w + 3;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// -----------------------------------------------------------------------------
// ex_mem_pipe_reg_if
//   One valid/ready channel carrying an EX->MEM instruction.
//   master: drives valid + payload, receives ready.
//   slave : receives valid + payload, drives ready.
//
//   Handshake: a transfer happens on a rising clk edge where valid & ready are
//   both 1. A master holding valid keeps the payload stable until that edge;
//   ready may be asserted with or without valid and carries no meaning alone.
// -----------------------------------------------------------------------------
interface ex_mem_pipe_reg_if
  import arm_pipe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEST_W = DEFAULT_DEST_W
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] val_rm;
  logic [DEST_W-1:0] dest;
  logic              wb_en;
  logic              mem_r_en;
  logic              mem_w_en;

  modport master (
    output valid, pc, alu_res, val_rm, dest, wb_en, mem_r_en, mem_w_en,
    input  ready
  );

  modport slave (
    input  valid, pc, alu_res, val_rm, dest, wb_en, mem_r_en, mem_w_en,
    output ready
  );

endinterface

// File: rtl/ex_mem_pipe_reg_skid_slot.sv
// -----------------------------------------------------------------------------
// pipe_skid_slot
//   One pipeline entry: a valid flop plus a payload register.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     clear             empty the slot (wins over load); payload zeroed too
//     load              capture d_valid / d_payload
//     d_valid, d_payload next contents
//     q_valid, q_payload current contents
// -----------------------------------------------------------------------------
module pipe_skid_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         d_valid,
  input  logic [W-1:0] d_payload,
  output logic         q_valid,
  output logic [W-1:0] q_payload
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid   <= 1'b0;
      q_payload <= '0;
    end else if (clear) begin
      q_valid   <= 1'b0;
      q_payload <= '0;
    end else if (load) begin
      q_valid   <= d_valid;
      q_payload <= d_payload;
    end
  end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// -----------------------------------------------------------------------------
// ex_mem_pipe_reg
//   EX->MEM pipeline register with valid/ready handshake, optional skid entry
//   and synchronous flush. Carries PC, ALU result, Val_Rm, Dest and WB/MEM
//   controls from the EX stage to the MEM stage.
//   Parameters:
//     DATA_W   width of pc / alu_res / val_rm
//     DEST_W   width of dest
//     SKID_EN  1: MAIN + SKID entries, in_if.ready is a flop output
//              0: MAIN only, in_if.ready = out_if.ready | !out_if.valid
//   Ports:
//     clk, rst  clock, asynchronous active-high reset
//     flush     kill every held entry and any same-cycle input transfer
//     in_if     slave side facing EX
//     out_if    master side facing MEM (driven straight from MAIN)
//     state     debug: ST_EMPTY / ST_ONE / ST_TWO occupancy
// -----------------------------------------------------------------------------
module ex_mem_pipe_reg
  import arm_pipe_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int DEST_W  = DEFAULT_DEST_W,
  parameter bit SKID_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  ex_mem_pipe_reg_if.slave    in_if,
  ex_mem_pipe_reg_if.master   out_if,
  output pipe_state_t         state
);

  localparam int PW = payload_w(DATA_W, DEST_W);

  logic          main_v;
  logic          skid_v;
  logic [PW-1:0] main_payload;
  logic [PW-1:0] skid_payload;
  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_d;
  logic          main_d_valid;
  logic          main_load;
  logic          in_ready;
  logic          rdy_q;
  logic          rdy_d;
  logic          in_fire;
  logic          out_fire;

  assign in_fire  = in_if.valid & in_ready;
  assign out_fire = main_v & out_if.ready;

  // Controls are gated by the transfer itself, so an entry loaded without a
  // real instruction can never present an enable.
  assign in_payload = {in_if.pc, in_if.alu_res, in_if.val_rm, in_if.dest,
                       in_if.wb_en    & in_fire,
                       in_if.mem_r_en & in_fire,
                       in_if.mem_w_en & in_fire};

  // MAIN refills whenever it is empty or its entry leaves; the older SKID
  // entry has priority over the input to keep order.
  assign main_load    = !main_v | out_fire;
  assign main_d_valid = skid_v | in_fire;
  assign main_d       = skid_v ? skid_payload : in_payload;

  pipe_skid_slot #(.W(PW)) u_main (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .load      (main_load),
    .d_valid   (main_d_valid),
    .d_payload (main_d),
    .q_valid   (main_v),
    .q_payload (main_payload)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic skid_load;
      logic skid_clear;

      // Overflow: MAIN is busy and stalled while a new instruction arrives.
      assign skid_load  = main_v & !out_fire & in_fire & !skid_v;
      assign skid_clear = flush | (skid_v & out_fire);

      pipe_skid_slot #(.W(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (skid_clear),
        .load      (skid_load),
        .d_valid   (1'b1),
        .d_payload (in_payload),
        .q_valid   (skid_v),
        .q_payload (skid_payload)
      );

      // Ready for next cycle is the complement of the next SKID valid, so the
      // flop needs nothing from out_if.ready beyond this cycle's fire.
      assign rdy_d    = !(skid_load | (skid_v & !out_fire));
      assign in_ready = rdy_q;
    end else begin : g_no_skid
      assign skid_v       = 1'b0;
      assign skid_payload = '0;
      assign rdy_d        = 1'b1;
      assign in_ready     = rdy_q & (out_if.ready | !main_v);
    end
  endgenerate

  // rdy_q holds ready low through reset and for the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b0;
    end else if (flush) begin
      rdy_q <= 1'b1;
    end else begin
      rdy_q <= rdy_d;
    end
  end

  assign in_if.ready = in_ready;
  assign out_if.valid = main_v;
  assign {out_if.pc, out_if.alu_res, out_if.val_rm, out_if.dest,
          out_if.wb_en, out_if.mem_r_en, out_if.mem_w_en} = main_payload;

  always_comb begin
    state = ST_EMPTY;
    if (skid_v) begin
      state = ST_TWO;
    end else if (main_v) begin
      state = ST_ONE;
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_pipe_reg
//   Directed checks on a SKID_EN=1 instance (reset, streaming, backpressure,
//   flush, store fields, control gating) and a SKID_EN=0 instance (ready path),
//   then random valid/ready/flush on both with per-instance expected queues.
// -----------------------------------------------------------------------------
module tb_ex_mem_pipe_reg;
  import arm_pipe_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  ex_mem_pipe_reg_if in1 ();
  ex_mem_pipe_reg_if out1 ();
  ex_mem_pipe_reg_if in0 ();
  ex_mem_pipe_reg_if out0 ();
  pipe_state_t state1;
  pipe_state_t state0;

  ex_mem_pipe_reg #(.SKID_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_if(in1.slave), .out_if(out1.master), .state(state1)
  );

  ex_mem_pipe_reg #(.SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_if(in0.slave), .out_if(out0.master), .state(state0)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [PAYLOAD_W-1:0] exp_q1[$];
  logic [PAYLOAD_W-1:0] exp_q0[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ex_mem_payload_t mk(input logic [31:0] pc, input logic [31:0] alu,
                                         input logic [31:0] rm, input logic [3:0] dest,
                                         input logic wb, input logic mr, input logic mw);
    ex_mem_payload_t p;
    p.pc = pc; p.alu_res = alu; p.val_rm = rm; p.dest = dest;
    p.wb_en = wb; p.mem_r_en = mr; p.mem_w_en = mw;
    return p;
  endfunction

  function automatic ex_mem_payload_t rnd_payload();
    return mk($urandom, $urandom, $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endfunction

  function automatic ex_mem_payload_t out_p(input int d);
    if (d == 1)
      return mk(out1.pc, out1.alu_res, out1.val_rm, out1.dest, out1.wb_en, out1.mem_r_en, out1.mem_w_en);
    return mk(out0.pc, out0.alu_res, out0.val_rm, out0.dest, out0.wb_en, out0.mem_r_en, out0.mem_w_en);
  endfunction

  // ---------------- drivers ----------------
  task automatic drive1(input logic v, input ex_mem_payload_t p);
    in1.valid = v; in1.pc = p.pc; in1.alu_res = p.alu_res; in1.val_rm = p.val_rm;
    in1.dest = p.dest; in1.wb_en = p.wb_en; in1.mem_r_en = p.mem_r_en; in1.mem_w_en = p.mem_w_en;
  endtask

  task automatic drive0(input logic v, input ex_mem_payload_t p);
    in0.valid = v; in0.pc = p.pc; in0.alu_res = p.alu_res; in0.val_rm = p.val_rm;
    in0.dest = p.dest; in0.wb_en = p.wb_en; in0.mem_r_en = p.mem_r_en; in0.mem_w_en = p.mem_w_en;
  endtask

  // Called after inputs settle, before the next rising edge: checks occupancy
  // against the expected queue, then applies the transfers that edge will do.
  task automatic score(input int d);
    logic iv, ir, ov, orr;
    logic [PAYLOAD_W-1:0] ip;
    logic [PAYLOAD_W-1:0] exp;
    int sz;
    if (d == 1) begin
      iv = in1.valid; ir = in1.ready; ov = out1.valid; orr = out1.ready;
      ip = mk(in1.pc, in1.alu_res, in1.val_rm, in1.dest, in1.wb_en, in1.mem_r_en, in1.mem_w_en);
      sz = exp_q1.size();
      check("rnd1_in_ready", ir, sz < 2);
    end else begin
      iv = in0.valid; ir = in0.ready; ov = out0.valid; orr = out0.ready;
      ip = mk(in0.pc, in0.alu_res, in0.val_rm, in0.dest, in0.wb_en, in0.mem_r_en, in0.mem_w_en);
      sz = exp_q0.size();
      check("rnd0_in_ready", ir, (sz == 0) || orr);
    end
    check($sformatf("rnd%0d_out_valid", d), ov, sz != 0);
    if (flush) begin
      if (d == 1) exp_q1.delete(); else exp_q0.delete();
    end else begin
      if (ov && orr && sz != 0) begin
        exp = (d == 1) ? exp_q1.pop_front() : exp_q0.pop_front();
        check($sformatf("rnd%0d_payload", d), out_p(d), exp);
      end
      if (iv && ir) begin
        if (d == 1) exp_q1.push_back(ip); else exp_q0.push_back(ip);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive1(1'b0, '0);
    drive0(1'b0, '0);
    out1.ready = 1'b0;
    out0.ready = 1'b0;

    // Reset state
    #1;
    check("rst_out_valid", out1.valid, 1'b0);
    check("rst_out_pc", out1.pc, 32'h0);
    check("rst_in_ready", in1.ready, 1'b0);
    check("rst_state", state1, ST_EMPTY);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rel_ready_low", in1.ready, 1'b0);
    @(negedge clk);
    check("rst_rel_ready1", in1.ready, 1'b1);
    check("rst_rel_ready0", in0.ready, 1'b1);

    // Streaming, no bubbles
    out1.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive1(1'b1, mk(32'(i * 4), 32'(i), 32'h0, 4'h1, 1'b1, 1'b0, 1'b0));
      @(negedge clk);
      check("stream_valid", out1.valid, 1'b1);
      check("stream_pc", out1.pc, 32'(i * 4));
      check("stream_ready", in1.ready, 1'b1);
    end
    drive1(1'b0, '0);
    @(negedge clk);
    check("stream_drained", out1.valid, 1'b0);

    // Backpressure into the skid entry
    out1.ready = 1'b0;
    drive1(1'b1, mk(32'h10, 32'h0, 32'h0, 4'h2, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    check("bp_pc_a", out1.pc, 32'h10);
    check("bp_ready_a", in1.ready, 1'b1);
    check("bp_state_one", state1, ST_ONE);
    drive1(1'b1, mk(32'h14, 32'h0, 32'h0, 4'h3, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    check("bp_ready_full", in1.ready, 1'b0);
    check("bp_pc_hold", out1.pc, 32'h10);
    check("bp_state_two", state1, ST_TWO);
    drive1(1'b0, '0);
    @(negedge clk);
    check("bp_pc_stable", out1.pc, 32'h10);
    check("bp_valid_stable", out1.valid, 1'b1);
    out1.ready = 1'b1;
    @(negedge clk);
    check("bp_pc_b", out1.pc, 32'h14);
    check("bp_ready_back", in1.ready, 1'b1);
    @(negedge clk);
    check("bp_empty", out1.valid, 1'b0);

    // Flush while two entries are held and a new one is offered
    out1.ready = 1'b0;
    drive1(1'b1, mk(32'h20, 32'h100, 32'h5, 4'h4, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    drive1(1'b1, mk(32'h24, 32'h104, 32'h6, 4'h5, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    check("fl_pre_state", state1, ST_TWO);
    drive1(1'b1, mk(32'h28, 32'h108, 32'h7, 4'h6, 1'b0, 1'b0, 1'b1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive1(1'b0, '0);
    check("fl_valid", out1.valid, 1'b0);
    check("fl_mem_w", out1.mem_w_en, 1'b0);
    check("fl_state", state1, ST_EMPTY);
    check("fl_ready", in1.ready, 1'b1);
    out1.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fl_no_reappear", out1.valid, 1'b0);
    end

    // Flush in ONE discards a same-cycle accepted input
    out1.ready = 1'b0;
    drive1(1'b1, mk(32'h30, 32'h0, 32'h0, 4'h7, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    check("fl1_pre_valid", out1.valid, 1'b1);
    drive1(1'b1, mk(32'h34, 32'h0, 32'h0, 4'h8, 1'b1, 1'b0, 1'b0));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive1(1'b0, '0);
    check("fl1_valid", out1.valid, 1'b0);
    check("fl1_wb", out1.wb_en, 1'b0);
    @(negedge clk);
    check("fl1_still_empty", out1.valid, 1'b0);

    // Store fields pass through unmodified; then an invalid beat with
    // controls high must not present enables
    out1.ready = 1'b1;
    drive1(1'b1, mk(32'h40, 32'hDEADBEEF, 32'h12345678, 4'hA, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    drive1(1'b0, mk(32'h44, 32'h1, 32'h2, 4'hF, 1'b1, 1'b1, 1'b1));
    check("st_alu", out1.alu_res, 32'hDEADBEEF);
    check("st_rm", out1.val_rm, 32'h12345678);
    check("st_dest", out1.dest, 4'hA);
    check("st_mem_w", out1.mem_w_en, 1'b1);
    check("st_wb", out1.wb_en, 1'b0);
    check("st_whole", out_p(1), mk(32'h40, 32'hDEADBEEF, 32'h12345678, 4'hA, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    check("gate_valid", out1.valid, 1'b0);
    check("gate_ctrl", {out1.wb_en, out1.mem_r_en, out1.mem_w_en}, 3'b000);

    // Asynchronous reset in the middle of a transfer
    out1.ready = 1'b0;
    drive1(1'b1, mk(32'h50, 32'h9, 32'h9, 4'h9, 1'b1, 1'b1, 1'b0));
    @(negedge clk);
    drive1(1'b1, mk(32'h54, 32'h9, 32'h9, 4'h9, 1'b1, 1'b1, 1'b0));
    check("mr_pre_valid", out1.valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mr_valid", out1.valid, 1'b0);
    check("mr_pc", out1.pc, 32'h0);
    check("mr_ctrl", {out1.wb_en, out1.mem_r_en}, 2'b00);
    check("mr_ready", in1.ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive1(1'b0, '0);
    #1;
    check("mr_ready_low", in1.ready, 1'b0);
    @(negedge clk);
    check("mr_ready_back", in1.ready, 1'b1);
    check("mr_empty", out1.valid, 1'b0);

    // Single-entry instance: ready follows out_ready while full
    out0.ready = 1'b0;
    drive0(1'b1, mk(32'h100, 32'h0, 32'h0, 4'h1, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    check("s0_pc", out0.pc, 32'h100);
    check("s0_ready_stall", in0.ready, 1'b0);
    out0.ready = 1'b1;
    drive0(1'b1, mk(32'h104, 32'h0, 32'h0, 4'h2, 1'b1, 1'b0, 1'b0));
    #1;
    check("s0_ready_pass", in0.ready, 1'b1);
    @(negedge clk);
    check("s0_pc_next", out0.pc, 32'h104);
    drive0(1'b0, '0);
    @(negedge clk);
    check("s0_empty", out0.valid, 1'b0);

    // Random valid/ready/flush on both instances
    exp_q1.delete();
    exp_q0.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      drive1($urandom_range(0, 9) < 7, rnd_payload());
      drive0($urandom_range(0, 9) < 7, rnd_payload());
      out1.ready = $urandom_range(0, 9) < 6;
      out0.ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 24) == 0;
      #1;
      score(1);
      score(0);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive1(1'b0, '0);
      drive0(1'b0, '0);
      out1.ready = 1'b1;
      out0.ready = 1'b1;
      flush = 1'b0;
      #1;
      score(1);
      score(0);
    end
    check("drain_q1", exp_q1.size(), 0);
    check("drain_q0", exp_q0.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
